// File: rtl/fft_pkg.sv
// Shared types for the radix-4 FFT datapath: complex sample and 4-sample group.
package fft_pkg;

    localparam int DATA_WIDTH  = 27;
    localparam int LABEL_WIDTH = 11;

    typedef struct packed {
        logic signed [DATA_WIDTH-1:0] re;
        logic signed [DATA_WIDTH-1:0] im;
    } cplx_t;

    typedef struct packed {
        cplx_t [3:0]            s;
        logic [LABEL_WIDTH-1:0] label;
    } group_t;

endpackage

// File: rtl/fft4_group_serializer_if.sv
// Group input from the twiddle stage and 1-wide valid/ready sample stream out.
interface fft4_group_serializer_if;
    import fft_pkg::*;

    logic                         in_valid;
    logic [LABEL_WIDTH-1:0]       in_label;
    logic signed [DATA_WIDTH-1:0] in_y0_r, in_y0_i, in_y1_r, in_y1_i;
    logic signed [DATA_WIDTH-1:0] in_y2_r, in_y2_i, in_y3_r, in_y3_i;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_r;
    logic signed [DATA_WIDTH-1:0] out_i;
    logic [LABEL_WIDTH+1:0]       out_addr;
    logic                         out_last;

    // master: the serializer
    modport master (
        input  in_valid, in_label,
        input  in_y0_r, in_y0_i, in_y1_r, in_y1_i, in_y2_r, in_y2_i, in_y3_r, in_y3_i,
        input  out_ready,
        output out_valid, out_r, out_i, out_addr, out_last
    );

    // slave: upstream stage and downstream consumer
    modport slave (
        output in_valid, in_label,
        output in_y0_r, in_y0_i, in_y1_r, in_y1_i, in_y2_r, in_y2_i, in_y3_r, in_y3_i,
        output out_ready,
        input  out_valid, out_r, out_i, out_addr, out_last
    );

endinterface

// File: rtl/fft4_group_fifo.sv
// Group FIFO; exposes the head and the entry behind it so the serializer can
// preload its output register on the same edge that pops the head.
module fft4_group_fifo
    import fft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  group_t                   wr_data,
    output group_t                   head,
    output group_t                   head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    group_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   rd_ptr_nx;

    assign rd_ptr_nx = rd_ptr + PW'(1);
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr_nx];
    assign full      = (level == DEPTH_L);
    assign empty     = (level == '0);

    // storage write; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr_nx;
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fft4_group_serializer.sv
// Buffers 4-wide groups from the twiddle stage and streams one complex word
// per cycle with its bin address {label, k}.
module fft4_group_serializer
    import fft_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int LAST_LABEL = 511
) (
    input  logic                   clk,
    input  logic                   rst,
    fft4_group_serializer_if.master bus,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LABEL_WIDTH-1:0] LAST_L = LABEL_WIDTH'(LAST_LABEL);
    localparam logic [LW-1:0] ONE_L = LW'(1);

    group_t in_grp, head, head_next, ld_grp;
    logic   full, empty;
    logic   accept, pop, space, push, load;
    logic [1:0] k, ld_k;

    logic signed [DATA_WIDTH-1:0] out_r_q, out_i_q;
    logic [LABEL_WIDTH+1:0]       out_addr_q;
    logic                         out_last_q;

    // pack the parallel stage outputs into one group word
    always_comb begin
        in_grp          = '0;
        in_grp.label    = bus.in_label;
        in_grp.s[0].re  = bus.in_y0_r;
        in_grp.s[0].im  = bus.in_y0_i;
        in_grp.s[1].re  = bus.in_y1_r;
        in_grp.s[1].im  = bus.in_y1_i;
        in_grp.s[2].re  = bus.in_y2_r;
        in_grp.s[2].im  = bus.in_y2_i;
        in_grp.s[3].re  = bus.in_y3_r;
        in_grp.s[3].im  = bus.in_y3_i;
    end

    // a pop frees a slot in the same cycle, so a full FIFO can still take a group
    assign accept = bus.out_valid & bus.out_ready;
    assign pop    = accept & (k == 2'd3);
    assign space  = ~full | pop;
    assign push   = bus.in_valid & space;
    assign load   = accept | (empty & push);

    fft4_group_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wr_data   (in_grp),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // select the word the output register shows after this edge
    always_comb begin
        ld_grp = head;
        ld_k   = k + 2'd1;
        if (pop || empty) begin
            ld_k   = 2'd0;
            ld_grp = (empty || level == ONE_L) ? in_grp : head_next;
        end
    end

    // read index and registered output word; holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k          <= '0;
            out_r_q    <= '0;
            out_i_q    <= '0;
            out_addr_q <= '0;
            out_last_q <= 1'b0;
        end else begin
            if (accept) k <= k + 2'd1;
            if (load) begin
                out_r_q    <= ld_grp.s[ld_k].re;
                out_i_q    <= ld_grp.s[ld_k].im;
                out_addr_q <= {ld_grp.label, ld_k};
                out_last_q <= (ld_grp.label == LAST_L) && (ld_k == 2'd3);
            end
        end
    end

    // sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       overflow <= 1'b0;
        else if (bus.in_valid & ~space) overflow <= 1'b1;
    end

    assign bus.out_valid = ~empty;
    assign bus.out_r     = out_r_q;
    assign bus.out_i     = out_i_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_fft4_group_serializer.sv
// Directed bench for fft4_group_serializer (DEPTH=4, LAST_LABEL=511).
module tb_fft4_group_serializer;

    logic       clk;
    logic       rst;
    logic       overflow;
    logic [2:0] level;
    int         n_checks;
    int         n_fail;

    fft4_group_serializer_if bus();

    fft4_group_serializer #(.DEPTH(4), .LAST_LABEL(511)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .overflow (overflow),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_group(input int label, input int base);
        bus.in_valid = 1'b1;
        bus.in_label = 11'(label);
        bus.in_y0_r  = 27'(base);     bus.in_y0_i = 27'(-base);
        bus.in_y1_r  = 27'(base + 1); bus.in_y1_i = 27'(-(base + 1));
        bus.in_y2_r  = 27'(base + 2); bus.in_y2_i = 27'(-(base + 2));
        bus.in_y3_r  = 27'(base + 3); bus.in_y3_i = 27'(-(base + 3));
    endtask

    task automatic chk_word(input string tag, input int addr, input int r, input int last);
        chk({tag, "_valid"}, int'(bus.out_valid), 1);
        chk({tag, "_addr"},  int'(bus.out_addr), addr);
        chk({tag, "_r"},     int'(bus.out_r), r);
        chk({tag, "_i"},     int'(bus.out_i), -r);
        chk({tag, "_last"},  int'(bus.out_last), last);
    endtask

    initial begin
        int e;
        int lbl;
        int labels [4];
        logic rdy;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b0;
        bus.out_ready = 1'b0;
        drive_group(0, 0);
        bus.in_valid = 1'b0;
        #1 rst = 1'b1;
        #2;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_r",     int'(bus.out_r), 0);
        chk("rst_addr",  int'(bus.out_addr), 0);
        chk("rst_last",  int'(bus.out_last), 0);
        chk("rst_ovf",   int'(overflow), 0);
        chk("rst_level", int'(level), 0);
        step();
        rst = 1'b0;
        step();

        // single group, label 5
        bus.out_ready = 1'b1;
        drive_group(5, 1);
        step();
        bus.in_valid = 1'b0;
        chk("single_level", int'(level), 1);
        for (int k = 0; k < 4; k++) begin
            chk_word("single", 20 + k, 1 + k, 0);
            step();
        end
        chk("single_empty", int'(bus.out_valid), 0);
        chk("single_level0", int'(level), 0);

        // backpressure, ready pattern 1,0,0,1,0,0,...
        bus.out_ready = 1'b0;
        drive_group(7, 10);
        step();
        bus.in_valid = 1'b0;
        e = 0;
        for (int c = 0; c < 20 && e < 4; c++) begin
            chk_word("bp", 28 + e, 10 + e, 0);
            rdy = (c % 3 == 0);
            bus.out_ready = rdy;
            step();
            if (rdy) e++;
        end
        chk("bp_words", e, 4);
        chk("bp_empty", int'(bus.out_valid), 0);

        // overflow: five pushes while stalled, label 4 dropped
        bus.out_ready = 1'b0;
        for (int l = 0; l < 5; l++) begin
            drive_group(l, 100 + 10 * l);
            step();
        end
        bus.in_valid = 1'b0;
        chk("ovf_level", int'(level), 4);
        chk("ovf_flag",  int'(overflow), 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk_word("ovf_drain", i, 100 + (i / 4) * 10 + (i % 4), 0);
            step();
        end
        chk("ovf_empty", int'(bus.out_valid), 0);
        chk("ovf_sticky", int'(overflow), 1);

        // reset clears the sticky flag
        bus.out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst2_ovf", int'(overflow), 0);
        #2 rst = 1'b0;
        step();

        // push on the k=3 accept of a full FIFO
        for (int l = 1; l < 5; l++) begin
            drive_group(l, 200 + 10 * l);
            step();
        end
        bus.in_valid = 1'b0;
        chk("pop_full_level", int'(level), 4);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk_word("pop_head", 4 + k, 210 + k, 0);
            step();
        end
        chk_word("pop_k3", 7, 213, 0);
        drive_group(9, 300);
        step();
        bus.in_valid = 1'b0;
        chk("pop_level", int'(level), 4);
        chk("pop_ovf",   int'(overflow), 0);
        labels = '{2, 3, 4, 9};
        for (int g = 0; g < 4; g++) begin
            lbl = labels[g];
            for (int k = 0; k < 4; k++) begin
                chk_word("pop_drain", lbl * 4 + k,
                         (lbl == 9) ? 300 + k : 200 + 10 * lbl + k, 0);
                step();
            end
        end
        chk("pop_empty", int'(level), 0);

        // frame end
        drive_group(511, 5);
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_word("frame", 2044 + k, 5 + k, (k == 3) ? 1 : 0);
            step();
        end
        chk("frame_empty", int'(bus.out_valid), 0);

        // async reset while the head sits at k=2
        drive_group(3, 50);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        chk_word("ar_k2", 14, 52, 0);
        rst = 1'b1;
        #1;
        chk("ar_valid", int'(bus.out_valid), 0);
        chk("ar_r",     int'(bus.out_r), 0);
        chk("ar_addr",  int'(bus.out_addr), 0);
        chk("ar_level", int'(level), 0);
        #2 rst = 1'b0;
        step();
        drive_group(6, 60);
        step();
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk_word("ar_next", 24 + k, 60 + k, 0);
            step();
        end
        chk("ar_empty", int'(bus.out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
